// File: rtl/bshift_defs.sv
// Shared constants and encodings for the shared barrel-shifter arbiter.
package bshift_defs;

    localparam int W   = 8;
    localparam int SHW = 3;

    localparam logic SH_LEFT  = 1'b1;
    localparam logic SH_RIGHT = 1'b0;
    localparam logic SH_LOG   = 1'b0;
    localparam logic SH_ARI   = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/bshift_arb_if.sv
// Requester and result handshake bundle for bshift_arb.
interface bshift_arb_if
    import bshift_defs::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 8,
    parameter int IDW  = 1
);

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_din;
    logic [NREQ*SHW-1:0] req_shamt;
    logic [NREQ-1:0]     req_lr;
    logic [NREQ-1:0]     req_al;
    logic                res_valid;
    logic                res_ready;
    logic [W-1:0]        res_dout;
    logic [IDW-1:0]      res_id;

    modport master (
        output req_valid, req_din, req_shamt,
        output req_lr, req_al, res_ready,
        input  req_ready, res_valid,
        input  res_dout, res_id
    );

    modport slave (
        input  req_valid, req_din, req_shamt,
        input  req_lr, req_al, res_ready,
        output req_ready, res_valid,
        output res_dout, res_id
    );

endinterface

// File: rtl/bshift_core.sv
// Combinational 8-bit barrel shifter, three mux stages (1/2/4).
module bshift_core
    import bshift_defs::*;
(
    input  logic [W-1:0]   din,
    input  logic [SHW-1:0] shamt,
    input  logic           lr,
    input  logic           al,
    output logic [W-1:0]   dout
);

    logic         left;
    logic         fill;
    logic [W-1:0] s1;
    logic [W-1:0] s2;

    assign left = (lr == SH_LEFT);
    // Fill bit for right shifts; sign only when arithmetic.
    assign fill = (al != SH_LOG) & (lr == SH_RIGHT) & din[W-1];

    assign s1 = !shamt[0] ? din
              : left ? {din[W-2:0], 1'b0}
              : {fill, din[W-1:1]};

    assign s2 = !shamt[1] ? s1
              : left ? {s1[W-3:0], 2'b00}
              : {{2{fill}}, s1[W-1:2]};

    assign dout = !shamt[2] ? s2
                : left ? {s2[W-5:0], 4'b0000}
                : {{4{fill}}, s2[W-1:4]};

endmodule

// File: rtl/bshift_arb.sv
// Round-robin arbiter sharing one barrel shifter; registered result + id.
module bshift_arb
    import bshift_defs::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 8,
    parameter int IDW  = 1
) (
    input logic        clk,
    input logic        rst_n,
    bshift_arb_if.slave bus
);

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gid;
    logic [IDW-1:0] nxt;
    logic [IDW:0]   nsum;
    logic [NREQ-1:0] gnt;
    logic           can_accept;
    logic           xfer;
    logic [W-1:0]   dout_q;
    logic [IDW-1:0] id_q;

    logic [W-1:0]   din_a [NREQ];
    logic [SHW-1:0] sh_a  [NREQ];
    logic [W-1:0]   sh_dout;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign din_a[g] = bus.req_din[g*W +: W];
        assign sh_a[g]  = bus.req_shamt[g*SHW +: SHW];
    end

    // Search from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        gnt = '0;
        gid = '0;
        sum = '0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            idx = sum[IDW-1:0];
            if (gnt == '0 && bus.req_valid[idx]) begin
                gnt[idx] = 1'b1;
                gid      = idx;
            end
        end
    end

    assign nsum = {1'b0, gid} + (IDW+1)'(1);
    assign nxt  = (nsum == (IDW+1)'(NREQ)) ? '0 : nsum[IDW-1:0];

    assign can_accept    = (state == ST_IDLE) | bus.res_ready;
    assign bus.req_ready = rst_n ? (gnt & {NREQ{can_accept}}) : '0;
    assign xfer          = |bus.req_ready;

    bshift_core u_core (
        .din   (din_a[gid]),
        .shamt (sh_a[gid]),
        .lr    (bus.req_lr[gid]),
        .al    (bus.req_al[gid]),
        .dout  (sh_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            dout_q <= '0;
            id_q   <= '0;
        end else if (xfer) begin
            state  <= ST_HOLD;
            rr_ptr <= nxt;
            dout_q <= sh_dout;
            id_q   <= gid;
        end else begin
            unique case (state)
                ST_IDLE: state <= ST_IDLE;
                ST_HOLD: if (bus.res_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.res_valid = (state == ST_HOLD);
    assign bus.res_dout  = dout_q;
    assign bus.res_id    = id_q;

endmodule
